// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module   : serial_adder_pkg
// Brief    : Shared state encodings for the bit-serial adder controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t c_st_idle = 2'd0;
  localparam state_t c_st_run  = 2'd1;
  localparam state_t c_st_done = 2'd2;

endpackage

`default_nettype wire

// File: rtl/full_adder_1bit.sv
// ============================================================================
// Module   : full_adder_1bit
// Brief    : Single-bit full adder cell.
// Revision : 1.0
// ============================================================================
`default_nettype none

module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic c_out,
  output logic s
);

  logic w_p;

  assign w_p   = a ^ b;
  assign s     = w_p ^ c_in;
  assign c_out = (a & b) | (c_in & w_p);

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module   : serial_adder_ctrl
// Brief    : Bit-serial adder, LSB first, one bit per clock, start/busy/done.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_sh_a;
  logic [WIDTH-1:0]   r_sh_b;
  logic [WIDTH-1:0]   r_sh_s;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_c_out;
  logic               w_fa_s;
  logic               w_fa_c_out;
  logic               w_accept;
  logic               w_last;

  full_adder_1bit u_fa (
    .a     (r_sh_a[0]),
    .b     (r_sh_b[0]),
    .c_in  (r_carry),
    .c_out (w_fa_c_out),
    .s     (w_fa_s)
  );

  // A new request is taken from IDLE and also straight out of DONE.
  assign w_accept = start && ((r_state == c_st_idle) || (r_state == c_st_done));
  assign w_last   = (r_state == c_st_run) && (r_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (start) w_state_nxt = c_st_run;
      c_st_run:  if (w_last) w_state_nxt = c_st_done;
      c_st_done: w_state_nxt = start ? c_st_run : c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    busy = (r_state == c_st_run);
    done = (r_state == c_st_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_sh_s  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
    end else if (w_accept) begin
      r_sh_a  <= a;
      r_sh_b  <= b;
      r_carry <= c_in;
      r_cnt   <= '0;
    end else if (r_state == c_st_run) begin
      // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
      r_sh_s  <= {w_fa_s, r_sh_s[WIDTH-1:1]};
      r_carry <= w_fa_c_out;
      r_sh_a  <= {1'b0, r_sh_a[WIDTH-1:1]};
      r_sh_b  <= {1'b0, r_sh_b[WIDTH-1:1]};
      r_cnt   <= r_cnt + c_cnt_w'(1);
      if (w_last) begin
        r_sum   <= {w_fa_s, r_sh_s[WIDTH-1:1]};
        r_c_out <= w_fa_c_out;
      end
    end
  end

  assign sum   = r_sum;
  assign c_out = r_c_out;

endmodule

`default_nettype wire

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It sequences one full_adder_1bit instance over two WIDTH-bit operands, LSB first, one bit per clock. A start/busy/done handshake brackets each operation. The N-bit result and carry-out are held in registers until the next operation completes. It is a small-area alternative to a ripple adder and provides a reusable sequencing block for lab datapaths.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new addition; sampled on rising clk edge
a  input  WIDTH  operand A; sampled only on the accepting edge
b  input  WIDTH  operand B; sampled only on the accepting edge
c_in  input  1  carry-in; sampled only on the accepting edge
busy  output  1  high while an addition is in progress (state RUN)
done  output  1  single-cycle pulse: result registers were just updated
sum  output  WIDTH  result register, A+B+c_in mod 2^WIDTH
c_out  output  1  carry-out of the result

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, c_out=0; shift registers, carry flop and bit counter cleared. Reset mid-operation aborts the operation with no done pulse; sum/c_out read 0.
- States: IDLE, RUN, DONE (registered; busy=(state==RUN), done=(state==DONE)).
- IDLE: on start=1, load sh_a<=a, sh_b<=b, carry<=c_in, cnt<=0, go RUN. Otherwise stay.
- RUN, each edge:
  - The full adder sees (sh_a[0], sh_b[0], carry).
  - Shift its s into sh_s from the MSB side (sh_s <= {s, sh_s[WIDTH-1:1]}).
  - carry<=c_out of adder; shift sh_a, sh_b right by 1 (zero fill); cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (last bit): also load sum<={s, sh_s[WIDTH-1:1]}, c_out<=adder c_out, go DONE.
- DONE: one cycle. If start=1, accept exactly as in IDLE (back-to-back; go RUN); else go IDLE.
- Latency: start accepted at edge E0 -> busy high after E0 for WIDTH cycles -> done high for exactly one cycle after edge E0+WIDTH. Back-to-back throughput is one result per WIDTH+1 cycles.
- start while RUN: ignored, no queueing; operands and c_in are not resampled.
- sum/c_out change only on the completion edge (or reset). They are stable during a subsequent RUN.
- Counter width is clog2(WIDTH). No overflow is possible because cnt resets on every accept.
- Operand inputs may change freely after the accepting edge.

Decomposition:
- Shared package/header serial_adder_pkg: state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Sub-module: one existing full_adder_1bit instance, port order (a, b, c_in, c_out, s), connected to sh_a[0], sh_b[0], carry.
- All sequencing lives in serial_adder_ctrl. No further hierarchy.

Test Plan:
- WIDTH=8, a=0x3C, b=0x42, c_in=0, one-cycle start -> busy for 8 cycles, done pulses once 8 edges after accept; sum=0x7E, c_out=0.
- a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1. Then a=0xA5, b=0x5A, c_in=1 -> sum=0x00, c_out=1. Then a=0x00, b=0x00, c_in=0 -> sum=0x00, c_out=0.
- Hold start=1 continuously with a=0x10, b=0x01 -> results 0x11 every 9 cycles. While busy, change a to 0xFF -> ignored until the next accept; sum stays 0x11 during each RUN.
- Pulse start again 3 cycles into RUN (a=0x01, b=0x01) -> no restart; the original result is delivered on schedule; done pulses exactly once.
- Assert rst_n=0 for 1 cycle at cycle 4 of a RUN -> busy, done, sum, c_out go 0 immediately (asynchronous); no done pulse; the next start works normally.
- WIDTH=2 instance, exhaustive over all a, b, c_in (32 cases) -> {c_out, sum} == a+b+c_in for each; done latency is 2 edges.
